serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor: computes diff = a - b - bin, one bit per clock, LSB first.
- Uses a single full-subtractor cell and a registered borrow flip-flop.
- Complements the team's combinational full-adder arithmetic cells as the subtract-direction datapath for area-constrained lab designs.
- Start/busy/done handshake. Results are registered and held until the next completion.

Parameters:
- WIDTH, 8, operand and result width in bits (>=2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend; latched on an accepted start
- b  input  WIDTH  subtrahend; latched on an accepted start
- bin  input  1  borrow-in; latched on an accepted start
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse; result valid
- diff  output  WIDTH  registered difference
- bout  output  1  registered final borrow-out (1 = unsigned a < b+bin)
- ovf  output  1  registered signed (two's-complement) overflow

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, diff=0, bout=0, ovf=0.
  - Shift registers, bit counter and borrow FF are all cleared.
  - Asserting reset mid-operation aborts immediately. No done pulse; the partial result is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start=1: latch a->sa, b->sb, bin->br; cnt=0; go to RUN.
  - Also capture sign bits a[WIDTH-1] and b[WIDTH-1].
- RUN (one bit per edge):
  - Cell inputs x=sa[0], y=sb[0], br.
  - d = x^y^br; br_next = (~x&y) | (~x&br) | (y&br).
  - sa and sb shift right by one. d shifts into the MSB of the result shift register. cnt++.
  - On the edge processing cnt=WIDTH-1, go to DONE. On that same edge:
    - diff <= final result register (including this bit);
    - bout <= br_next;
    - ovf <= (sign_a != sign_b) && (d != sign_a).
- DONE: done=1 for exactly this cycle. The next edge returns to IDLE unconditionally.
- Latency: start sampled at edge T; diff/bout/ovf update at edge T+WIDTH; done is high in the cycle following edge T+WIDTH.
  - Minimum start-to-start spacing is WIDTH+2 cycles.
- busy: 1 in RUN and DONE.
- start is ignored while busy, including during DONE. Operand changes while busy have no effect.
- start held high continuously: a new operation is accepted on the first edge in IDLE. Back-to-back results are therefore every WIDTH+2 cycles.
- diff/bout/ovf hold their last values through IDLE and the next RUN. They change only at a completion edge.
- Arithmetic is modulo 2^WIDTH. bout is the unsigned borrow and ovf is the signed overflow; the two are independent.
- All outputs are driven directly from flops. There are no combinational paths from inputs to outputs.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, bin=0, start 1 cycle -> busy high 9 cycles; done pulses 9 cycles after start edge; diff=0x02, bout=0, ovf=0.
- a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1, ovf=0. Then a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1, ovf=0.
- a=0x80, b=0x01 -> diff=0x7F, bout=0, ovf=1. Then a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
- Start pulsed again mid-RUN with different operands -> ignored; first result unchanged. Start held high for 30 cycles -> done pulses every 10 cycles, each with correct results.
- rst_n pulled low on the 4th RUN cycle -> busy, done, diff, bout and ovf are 0 immediately (asynchronously). After release, a fresh start completes normally with correct values.
- Randomized 1000 operand sets against the reference model (a-b-bin) mod 256 -> diff/bout/ovf match; done never asserted outside DONE; outputs stable between completions.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor: diff = a - b - bin, one bit per clock,
//   LSB first, using a single full-subtractor cell and a registered borrow.
//   A start is accepted only in IDLE. The result appears WIDTH edges later,
//   and done pulses for the one DONE cycle that follows.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   operation request, sampled only in IDLE
//   a      in   minuend (latched on accepted start)
//   b      in   subtrahend (latched on accepted start)
//   bin    in   borrow-in (latched on accepted start)
//   busy   out  high in RUN and DONE
//   done   out  one-cycle result-valid pulse
//   diff   out  registered difference, held until the next completion
//   bout   out  registered unsigned borrow-out (1 = a < b+bin)
//   ovf    out  registered two's-complement overflow
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] sa, sb, res;
    logic [CW-1:0]    cnt;
    logic             br, sign_a, sign_b;

    // Full-subtractor cell on the current LSBs
    logic x, y, d, br_nx, last;

    always_comb begin
        x     = sa[0];
        y     = sb[0];
        d     = x ^ y ^ br;
        br_nx = (~x & y) | (~x & br) | (y & br);
        last  = (cnt == CW'(WIDTH - 1));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decode the state register only, so no input reaches them combinationally
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Datapath: operand shifters, borrow FF, result shifter and held outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa     <= '0;
            sb     <= '0;
            res    <= '0;
            cnt    <= '0;
            br     <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sa     <= a;
                        sb     <= b;
                        br     <= bin;
                        cnt    <= '0;
                        sign_a <= a[WIDTH-1];
                        sign_b <= b[WIDTH-1];
                    end
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    br  <= br_nx;
                    res <= {d, res[WIDTH-1:1]};
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        // Final bit is d itself, so publish the shifted value directly
                        diff <= {d, res[WIDTH-1:1]};
                        bout <= br_nx;
                        ovf  <= (sign_a != sign_b) && (d != sign_a);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
